// File: rtl/fp_iter_div.sv
// Multi-cycle floating-point divide / reciprocal built on a restoring divider.
// Every operation, specials included, takes FRAC_W+4 clocks from accept to out_valid.
module fp_iter_div #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_op,
   input  logic [EXP_W+FRAC_W:0] in_a,
   input  logic [EXP_W+FRAC_W:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [EXP_W+FRAC_W:0] out_r,
   output logic [3:0]            out_flags
);
   localparam int W     = 1 + EXP_W + FRAC_W;
   localparam int CNT_W = $clog2(FRAC_W + 2);
   localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(FRAC_W + 1);
   localparam logic [EXP_W-1:0]        BIAS     = EXP_W'((1 << (EXP_W - 1)) - 1);
   localparam logic [EXP_W-1:0]        EXP_ONES = '1;
   localparam logic signed [EXP_W+1:0] EXP_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic signed [EXP_W+1:0] ONE_S    = (EXP_W+2)'(1);
   localparam logic [W-1:0]            NAN_VAL  = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, SETUP, ITER, NORM, DONE} state_t;
   state_t state, state_next;

   logic [W-1:0]            a_r, b_r;
   logic [FRAC_W+1:0]       rem;
   logic [FRAC_W:0]         div;
   logic [FRAC_W+1:0]       q;
   logic [CNT_W-1:0]        cnt;
   logic signed [EXP_W+1:0] exp_raw;
   logic                    sign_r;
   logic                    spec_hit_r;
   logic [W-1:0]            spec_val_r;
   logic [3:0]              spec_flags_r;

   logic                    sa, sb;
   logic [EXP_W-1:0]        ea, eb;
   logic [FRAC_W-1:0]       fa, fb;
   logic                    a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
   logic                    spec_hit;
   logic [W-1:0]            spec_val;
   logic [3:0]              spec_flags;
   logic signed [EXP_W+1:0] exp_calc;
   logic [FRAC_W+2:0]       diff;
   logic                    ge;
   logic signed [EXP_W+1:0] exp_n;
   logic [FRAC_W-1:0]       frac_n;
   logic [W-1:0]            res_val;
   logic [3:0]              res_flags;

   assign {sa, ea, fa} = a_r;
   assign {sb, eb, fb} = b_r;
   assign a_nan  = (ea == EXP_ONES) && (fa != '0);
   assign a_inf  = (ea == EXP_ONES) && (fa == '0);
   assign a_zero = (ea == '0);
   assign b_nan  = (eb == EXP_ONES) && (fb != '0);
   assign b_inf  = (eb == EXP_ONES) && (fb == '0);
   assign b_zero = (eb == '0);
   assign exp_calc = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed({2'b00, BIAS});

   assign diff = {1'b0, rem} - {2'b00, div};
   assign ge   = ~diff[FRAC_W+2];

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = SETUP;
         SETUP:   state_next = ITER;
         ITER:    if (cnt == LAST_CNT) state_next = NORM;
         NORM:    state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Special operands are classified once; the divider still runs so latency never varies.
   always_comb begin
      spec_hit   = 1'b1;
      spec_flags = 4'b0000;
      spec_val   = {sa ^ sb, {(EXP_W+FRAC_W){1'b0}}};
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_val   = NAN_VAL;
         spec_flags = 4'b1000;
      end else if (a_inf) begin
         spec_val = {sa ^ sb, EXP_ONES, {FRAC_W{1'b0}}};
      end else if (b_zero) begin
         spec_val   = {sa ^ sb, EXP_ONES, {FRAC_W{1'b0}}};
         spec_flags = 4'b0100;
      end else if (!(b_inf || a_zero)) begin
         spec_hit = 1'b0;
      end
   end

   always_comb begin
      exp_n     = q[FRAC_W+1] ? exp_raw : exp_raw - ONE_S;
      frac_n    = q[FRAC_W+1] ? q[FRAC_W:1] : q[FRAC_W-1:0];
      res_val   = {sign_r, exp_n[EXP_W-1:0], frac_n};
      res_flags = 4'b0000;
      if (spec_hit_r) begin
         res_val   = spec_val_r;
         res_flags = spec_flags_r;
      end else if (exp_n >= EXP_MAX) begin
         res_val   = {sign_r, EXP_ONES, {FRAC_W{1'b0}}};
         res_flags = 4'b0010;
      end else if (exp_n[EXP_W+1] || (exp_n == '0)) begin
         res_val   = {sign_r, {(EXP_W+FRAC_W){1'b0}}};
         res_flags = 4'b0001;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_r          <= '0;
         b_r          <= '0;
         rem          <= '0;
         div          <= '0;
         q            <= '0;
         cnt          <= '0;
         exp_raw      <= '0;
         sign_r       <= 1'b0;
         spec_hit_r   <= 1'b0;
         spec_val_r   <= '0;
         spec_flags_r <= '0;
         out_r        <= '0;
         out_flags    <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r <= in_op ? {1'b0, BIAS, {FRAC_W{1'b0}}} : in_a;
               b_r <= in_b;
            end
            SETUP: begin
               rem          <= {1'b0, 1'b1, fa};
               div          <= {1'b1, fb};
               q            <= '0;
               cnt          <= '0;
               exp_raw      <= exp_calc;
               sign_r       <= sa ^ sb;
               spec_hit_r   <= spec_hit;
               spec_val_r   <= spec_val;
               spec_flags_r <= spec_flags;
            end
            ITER: begin
               rem <= ge ? (diff[FRAC_W+1:0] << 1) : (rem << 1);
               q   <= {q[FRAC_W:0], ge};
               if (cnt != LAST_CNT) cnt <= cnt + 1'b1;
            end
            NORM: begin
               out_r     <= res_val;
               out_flags <= res_flags;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_iter_div.sv
// Self-checking bench: drives an 8/7 and a 5/10 instance side by side and compares
// both against an integer-arithmetic reference of the divide rules.
module tb_fp_iter_div;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_op, out_ready;
   logic [15:0] in_a, in_b, in_a2, in_b2;
   logic        in_ready, out_valid, in_ready2, out_valid2;
   logic [15:0] out_r, out_r2;
   logic [3:0]  out_flags, out_flags2;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   fp_iter_div #(.EXP_W(8), .FRAC_W(7)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_flags(out_flags));

   fp_iter_div #(.EXP_W(5), .FRAC_W(10)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_op(in_op),
      .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_ready(out_ready),
      .out_r(out_r2), .out_flags(out_flags2));

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference result {nv,dz,ov,uf, word} from plain integer arithmetic.
   function automatic logic [19:0] refDiv(input int ew, input int fw, input logic op,
                                          input logic [15:0] av, input logic [15:0] bv);
      int bias, emax, fmask, a, b, sa, sb, ea, eb, fa, fb, s, q, e, fr, infv, zerov, nanv;
      bit an, ai, az, bn, bi, bz;
      bias  = (1 << (ew - 1)) - 1;
      emax  = (1 << ew) - 1;
      fmask = (1 << fw) - 1;
      a  = op ? (bias << fw) : int'(av);
      b  = int'(bv);
      sa = (a >> (ew + fw)) & 1;
      sb = (b >> (ew + fw)) & 1;
      ea = (a >> fw) & emax;
      eb = (b >> fw) & emax;
      fa = a & fmask;
      fb = b & fmask;
      s  = sa ^ sb;
      infv  = (s << (ew + fw)) | (emax << fw);
      zerov = s << (ew + fw);
      nanv  = (emax << fw) | (1 << (fw - 1));
      an = (ea == emax) && (fa != 0);
      ai = (ea == emax) && (fa == 0);
      az = (ea == 0);
      bn = (eb == emax) && (fb != 0);
      bi = (eb == emax) && (fb == 0);
      bz = (eb == 0);
      if (an || bn || (ai && bi) || (az && bz)) return {4'b1000, 16'(nanv)};
      if (ai) return {4'b0000, 16'(infv)};
      if (bz) return {4'b0100, 16'(infv)};
      if (bi || az) return {4'b0000, 16'(zerov)};
      q = (((1 << fw) | fa) << (fw + 1)) / ((1 << fw) | fb);
      e = ea - eb + bias;
      if (q >= (1 << (fw + 1))) fr = (q >> 1) & fmask;
      else begin
         fr = q & fmask;
         e--;
      end
      if (e >= emax) return {4'b0010, 16'(infv)};
      if (e <= 0) return {4'b0001, 16'(zerov)};
      return {4'b0000, 16'((s << (ew + fw)) | (e << fw) | fr)};
   endfunction

   function automatic logic [15:0] randVal(input int ew, input int fw);
      int bias, e;
      bias = (1 << (ew - 1)) - 1;
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      e = bias - 4 + int'($urandom_range(0, 8));
      return 16'(($urandom_range(0, 1) << (ew + fw)) | (e << fw) | ($urandom & ((1 << fw) - 1)));
   endfunction

   task automatic applyStimulus(input logic op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] a2, input logic [15:0] b2);
      checkOutput("ready_before_accept", {in_ready, in_ready2}, 2'b11);
      in_op = op; in_a = a; in_b = b; in_a2 = a2; in_b2 = b2;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = 16'($urandom); in_b = 16'($urandom);
      in_a2 = 16'($urandom); in_b2 = 16'($urandom);
      in_op = 1'($urandom);
   endtask

   task automatic waitResults(input string tag, input logic [19:0] exp_a, input logic [19:0] exp_b);
      int lat_a = -1;
      int lat_b = -1;
      bit ready_low = 1'b1;
      for (int cyc = 1; cyc <= 40 && (lat_a < 0 || lat_b < 0); cyc++) begin
         @(posedge clk); #1;
         if (lat_a < 0 && out_valid) lat_a = cyc;
         if (lat_b < 0 && out_valid2) lat_b = cyc;
         if (in_ready || in_ready2) ready_low = 1'b0;
      end
      checkOutput({tag, "_lat_a"}, lat_a, 11);
      checkOutput({tag, "_lat_b"}, lat_b, 14);
      checkOutput({tag, "_ready_low"}, 32'(ready_low), 1);
      checkOutput({tag, "_res_a"}, {out_flags, out_r}, exp_a);
      checkOutput({tag, "_res_b"}, {out_flags2, out_r2}, exp_b);
   endtask

   task automatic handshake(input string tag, input logic [19:0] exp_a);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput({tag, "_idle"}, {in_ready, out_valid, in_ready2, out_valid2}, 4'b1010);
      checkOutput({tag, "_keep"}, {out_flags, out_r}, exp_a);
   endtask

   task automatic runOp(input string tag, input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] a2, input logic [15:0] b2,
                        input logic [19:0] exp_a, input logic [19:0] exp_b);
      applyStimulus(op, a, b, a2, b2);
      waitResults(tag, exp_a, exp_b);
      handshake(tag, exp_a);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        op;
      logic [15:0] a, b, a2, b2, ya, yb, ya2, yb2;
      bit          stable;
      logic [19:0] held;

      reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_a2 = '0; in_b2 = '0;
      #12;
      checkOutput("reset_a", {in_ready, out_valid, out_flags, out_r}, {2'b10, 20'h0});
      checkOutput("reset_b", {in_ready2, out_valid2, out_flags2, out_r2}, {2'b10, 20'h0});
      @(posedge clk); #1;
      reset = 1'b0;

      runOp("div_6_3",   1'b0, 16'h40C0, 16'h4040, 16'h4600, 16'h4200, 20'h0_4000, 20'h0_4000);
      runOp("recip_3",   1'b1, 16'h0000, 16'h4040, 16'h0000, 16'h4200, 20'h0_3EAA, 20'h0_3555);
      runOp("recip_m2",  1'b1, 16'h0000, 16'hC000, 16'h0000, 16'hC000, 20'h0_BF00, 20'h0_B800);
      runOp("div_zero",  1'b0, 16'h3F80, 16'h0000, 16'h3C00, 16'h0000, 20'h4_7F80, 20'h4_7C00);
      runOp("zero_zero", 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 20'h8_7FC0, 20'h8_7E00);
      runOp("nan_in",    1'b0, 16'h7FC1, 16'h3F80, 16'h7C01, 16'h3C00, 20'h8_7FC0, 20'h8_7E00);
      runOp("recip_inf", 1'b1, 16'h0000, 16'h7F80, 16'h0000, 16'h7C00, 20'h0_0000, 20'h0_0000);
      runOp("underflow", 1'b1, 16'h0000, 16'h7F00, 16'h0000, 16'h7800, 20'h1_0000, 20'h1_0000);
      runOp("overflow",  1'b0, 16'h7F00, 16'h3E80, 16'h7800, 16'h3400, 20'h2_7F80, 20'h2_7C00);

      // Backpressure: result held for 20 cycles while new operands wave around.
      applyStimulus(1'b0, 16'h40C0, 16'h4040, 16'h4600, 16'h4200);
      waitResults("bp", 20'h0_4000, 20'h0_4000);
      held = {out_flags, out_r};
      stable = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_a = 16'($urandom); in_b = 16'($urandom); in_op = 1'($urandom);
         in_a2 = 16'($urandom); in_b2 = 16'($urandom);
         @(posedge clk); #1;
         if ({out_flags, out_r} !== held || in_ready || !out_valid) stable = 1'b0;
      end
      checkOutput("bp_stable", 32'(stable), 1);
      ya = 16'h4248; yb = 16'h3FC0; ya2 = 16'h4490; yb2 = 16'h3E00;
      in_op = 1'b0; in_a = ya; in_b = yb; in_a2 = ya2; in_b2 = yb2;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp_release", {in_ready, out_valid, in_ready2, out_valid2}, 4'b1010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp_accept", {in_ready, in_ready2}, 2'b00);
      waitResults("bp_next", refDiv(8, 7, 1'b0, ya, yb), refDiv(5, 10, 1'b0, ya2, yb2));
      handshake("bp_next", refDiv(8, 7, 1'b0, ya, yb));

      // Asynchronous reset in the middle of the iterations.
      applyStimulus(1'b0, 16'h40C0, 16'h4040, 16'h4600, 16'h4200);
      repeat (6) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("rst_mid_a", {in_ready, out_valid, out_flags, out_r}, {2'b10, 20'h0});
      checkOutput("rst_mid_b", {in_ready2, out_valid2, out_flags2, out_r2}, {2'b10, 20'h0});
      @(posedge clk); #1;
      reset = 1'b0;
      runOp("after_rst", 1'b0, 16'h40C0, 16'h4040, 16'h4600, 16'h4200, 20'h0_4000, 20'h0_4000);

      for (int i = 0; i < 30; i++) begin
         op = 1'($urandom_range(0, 1));
         a = randVal(8, 7); b = randVal(8, 7);
         a2 = randVal(5, 10); b2 = randVal(5, 10);
         runOp($sformatf("rand%0d", i), op, a, b, a2, b2,
               refDiv(8, 7, op, a, b), refDiv(5, 10, op, a2, b2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
